// File: rtl/row_buf_scheduler_pkg.sv
// Shared encodings and ring geometry for the row buffer scheduler.
// The row RAM is a 4-bank ring indexed by 2-bit bank numbers.
package row_buf_scheduler_pkg;

  localparam int BANK_NUM = 4;
  localparam int BANK_W   = 2;
  localparam int RES_W    = 3;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LOAD   = 5'b00010,
    S_ISSUE  = 5'b00100,
    S_BUSY   = 5'b01000,
    S_FINISH = 5'b10000
  } state_t;

  localparam logic [3*BANK_W-1:0] SEL_RST = 6'b100100;

  function automatic logic [3*BANK_W-1:0] bank_sel(
    input logic [BANK_W-1:0] base
  );
    logic [BANK_W-1:0] b1;
    logic [BANK_W-1:0] b2;
    b1 = base + BANK_W'(1);
    b2 = base + BANK_W'(2);
    return {b2, b1, base};
  endfunction

endpackage

// File: rtl/row_buf_scheduler_row_ring_counter.sv
// Ring bookkeeping: write bank, window base bank and resident row count.
// Residency is exposed both registered and as its next-cycle value.
module row_ring_counter
  import row_buf_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_wr_done,
  input  logic              i_retire,
  output logic [BANK_W-1:0] o_wr_bank,
  output logic [BANK_W-1:0] o_base,
  output logic [RES_W-1:0]  o_res,
  output logic [RES_W-1:0]  o_res_nxt
);

  logic [BANK_W-1:0] r_wr_bank;
  logic [BANK_W-1:0] r_base;
  logic [RES_W-1:0]  r_res;
  logic [RES_W-1:0]  w_res_nxt;

  // A row landing and a row retiring in one cycle cancel out.
  always_comb begin
    w_res_nxt = r_res;
    if (i_clr)
      w_res_nxt = '0;
    else if (i_wr_done && !i_retire)
      w_res_nxt = r_res + RES_W'(1);
    else if (i_retire && !i_wr_done)
      w_res_nxt = r_res - RES_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_bank <= '0;
      r_base    <= '0;
      r_res     <= '0;
    end else begin
      r_res <= w_res_nxt;
      if (i_clr)
        r_wr_bank <= '0;
      else if (i_wr_done)
        r_wr_bank <= r_wr_bank + BANK_W'(1);
      if (i_clr)
        r_base <= '0;
      else if (i_retire)
        r_base <= r_base + BANK_W'(1);
    end
  end

  assign o_wr_bank = r_wr_bank;
  assign o_base    = r_base;
  assign o_res     = r_res;
  assign o_res_nxt = w_res_nxt;

endmodule

// File: rtl/row_buf_scheduler.sv
// Sequences the 3-row window into the row expander.
// Writes loader rows into a 4-bank ring and issues windows as rows land.
module row_buf_scheduler
  import row_buf_scheduler_pkg::*;
#(
  parameter int CHANNEL_IN_NUM     = 16,
  parameter int WIDTH_RAM_SIZE     = 12,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM  = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Start,
  input  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding,
  input  logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG,
  input  logic                          S_Valid,
  output logic                          S_Ready,
  output logic [WIDTH_RAM_SIZE-1:0]     Wr_Addr,
  output logic [BANK_NUM-1:0]           Wr_En,
  output logic                          M_Start,
  output logic                          Row_Compute_Sign,
  output logic [3*BANK_W-1:0]           Rd_Bank_Sel,
  input  logic                          Row_Done,
  output logic                          Layer_Done
);

  localparam int WF = WIDTH_FEATURE_SIZE;
  localparam int WR = WIDTH_RAM_SIZE;
  localparam int WC = WIDTH_CHANNEL_NUM;
  localparam int WP = WF + WC;
  localparam int GS = $clog2(CHANNEL_IN_NUM);

  state_t            r_state;
  logic [WF-1:0]     r_rows;
  logic [WR-1:0]     r_words;
  logic [WF-1:0]     r_cmp_row;
  logic [WF-1:0]     r_wr_row;
  logic [WR-1:0]     r_wr_addr;
  logic              r_s_ready;
  logic              r_m_start;
  logic              r_rcs;
  logic              r_layer_done;
  logic [3*BANK_W-1:0] r_sel;

  logic [WC-1:0]     w_groups;
  logic [WP-1:0]     w_r_ext;
  logic [WP-1:0]     w_g_ext;
  logic [WR-1:0]     w_words;
  logic              w_degen;
  logic              w_go;
  logic              w_accept;
  logic              w_row_end;
  logic              w_retire;
  logic              w_finish;
  logic              w_active;
  logic [WF-1:0]     w_wr_row_nxt;
  logic [WF-1:0]     w_cmp_nxt;
  logic              w_s_ready_nxt;
  logic [BANK_W-1:0] w_wr_bank;
  logic [BANK_W-1:0] w_base;
  logic [RES_W-1:0]  w_res;
  logic [RES_W-1:0]  w_res_nxt;

  assign w_groups = Channel_In_Num_REG >> GS;
  assign w_r_ext  = WP'(Row_Num_After_Padding);
  assign w_g_ext  = WP'(w_groups);
  assign w_words  = WR'(w_r_ext * w_g_ext);
  assign w_degen  = (Row_Num_After_Padding < WF'(3)) ||
                    (w_groups == '0);

  assign w_go      = (r_state == S_IDLE) && Start && !w_degen;
  assign w_accept  = S_Valid && r_s_ready;
  assign w_row_end = w_accept && (r_wr_addr == r_words - WR'(1));
  assign w_retire  = (r_state == S_BUSY) && Row_Done;
  assign w_finish  = (r_state == S_FINISH);
  assign w_active  = (r_state != S_IDLE) && !w_finish;

  assign w_wr_row_nxt = w_row_end ? r_wr_row + WF'(1) : r_wr_row;
  assign w_cmp_nxt    = r_cmp_row + WF'(1);

  // Ready is registered, so it is judged on next-cycle occupancy.
  assign w_s_ready_nxt = w_go ||
    (w_active && (w_wr_row_nxt < r_rows) &&
     (w_res_nxt < RES_W'(BANK_NUM)));

  row_ring_counter u_ring (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_go || w_finish),
    .i_wr_done (w_row_end),
    .i_retire  (w_retire),
    .o_wr_bank (w_wr_bank),
    .o_base    (w_base),
    .o_res     (w_res),
    .o_res_nxt (w_res_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_addr <= '0;
      r_wr_row  <= '0;
      r_s_ready <= 1'b0;
    end else begin
      r_s_ready <= w_s_ready_nxt;
      if (w_go) begin
        r_wr_addr <= '0;
        r_wr_row  <= '0;
      end else if (w_accept) begin
        r_wr_row  <= w_wr_row_nxt;
        r_wr_addr <= w_row_end ? '0 : r_wr_addr + WR'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rows       <= '0;
      r_words      <= '0;
      r_cmp_row    <= '0;
      r_m_start    <= 1'b0;
      r_rcs        <= 1'b0;
      r_layer_done <= 1'b0;
      r_sel        <= SEL_RST;
    end else begin
      r_m_start    <= 1'b0;
      r_rcs        <= 1'b0;
      r_layer_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (Start && w_degen) begin
            r_layer_done <= 1'b1;
          end else if (w_go) begin
            r_state   <= S_LOAD;
            r_m_start <= 1'b1;
            r_rows    <= Row_Num_After_Padding;
            r_words   <= w_words;
            r_cmp_row <= '0;
          end
        end
        S_LOAD: begin
          if (w_res >= RES_W'(3))
            r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_rcs   <= 1'b1;
          r_sel   <= bank_sel(w_base);
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (Row_Done) begin
            r_cmp_row <= w_cmp_nxt;
            if (w_cmp_nxt == r_rows - WF'(2))
              r_state <= S_FINISH;
            else
              r_state <= S_LOAD;
          end
        end
        S_FINISH: begin
          r_layer_done <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign S_Ready          = r_s_ready;
  assign Wr_Addr          = r_wr_addr;
  assign Wr_En            = w_accept ? (BANK_NUM'(1) << w_wr_bank) : '0;
  assign M_Start          = r_m_start;
  assign Row_Compute_Sign = r_rcs;
  assign Rd_Bank_Sel      = r_sel;
  assign Layer_Done       = r_layer_done;

endmodule

// File: doc/row_buf_scheduler.md
# row_buf_scheduler

Controller that sequences the 3-row window feeding the 3→9 row-expansion stage. It writes incoming padded feature rows into a 4-bank row RAM ring and tracks which rows are resident. When three consecutive rows are available it issues `Row_Compute_Sign` together with the three bank indices, waits for the consumer to finish, then retires the oldest row. It sits between the feature loader and the row expander and owns layer start/finish for that pair.

## Interface
- `CHANNEL_IN_NUM`, 16: input channels per RAM word (channel group size).
- `WIDTH_RAM_SIZE`, 12: row-bank address width.
- `WIDTH_FEATURE_SIZE`, 12: width of padded row length and row counters.
- `WIDTH_CHANNEL_NUM`, 10: width of the channel count.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `Start` in 1: layer start pulse; ignored unless in IDLE.
- `Row_Num_After_Padding` in WIDTH_FEATURE_SIZE: padded rows = padded columns (R); latched at Start.
- `Channel_In_Num_REG` in WIDTH_CHANNEL_NUM: input channels; groups G = value>>4; latched at Start.
- `S_Valid` in 1: loader offers one word.
- `S_Ready` out 1: word accepted when `S_Valid && S_Ready`.
- `Wr_Addr` out WIDTH_RAM_SIZE: write address within the bank.
- `Wr_En` out 4: one-hot bank write enable, equal to `S_Valid && S_Ready` decoded by write bank.
- `M_Start` out 1: one-cycle layer-start pulse to the consumer.
- `Row_Compute_Sign` out 1: one-cycle window-ready pulse.
- `Rd_Bank_Sel` out 6: {bottom, middle, top} 2-bit bank indices; stable from the issue cycle until `Row_Done`.
- `Row_Done` in 1: consumer finished the current window (one-cycle pulse).
- `Layer_Done` out 1: one-cycle pulse at layer end.

## Operation
- Latched config at Start:
  - W = R×G words per row, truncated to WIDTH_RAM_SIZE; a product that overflows is an illegal config.
  - Total rows = R; windows = R−2.
- Degenerate config (R<3 or G=0): `Layer_Done` pulses the cycle after Start; no writes, no issues; return to IDLE.
- Write side (runs concurrently with issue):
  - `S_Ready` = active && Wr_Row<R && Resident<4.
  - Each accept increments `Wr_Addr`. At W−1 it wraps to 0, Wr_Bank=(Wr_Bank+1) mod 4, Wr_Row+1, Resident+1.
- Issue FSM states:
  - IDLE: on Start → LOAD; pulse `M_Start`; clear all counters.
  - LOAD: when Resident≥3 → ISSUE.
  - ISSUE (1 cycle): pulse `Row_Compute_Sign`; `Rd_Bank_Sel` = {base+2, base+1, base} mod 4 → BUSY.
  - BUSY: on `Row_Done`, base+1, Resident−1, Cmp_Row+1. If Cmp_Row+1 = R−2 → FINISH, else → LOAD.
  - FINISH (1 cycle): pulse `Layer_Done`; Resident, base, Wr_Bank cleared → IDLE.
- Simultaneous row-write completion and `Row_Done`: Resident unchanged.
- `Row_Done` outside BUSY is ignored.
- `S_Valid` while not active is ignored (`S_Ready`=0).

## Timing
- Reset values: `S_Ready`=0, `Wr_Addr`=0, `Wr_En`=0, `M_Start`=0, `Row_Compute_Sign`=0, `Rd_Bank_Sel`=6'b100100 (2,1,0), `Layer_Done`=0. Reset mid-layer abandons the layer with no `Layer_Done`.
- `M_Start` is registered; it pulses the cycle after Start is sampled in IDLE.
- All outputs are registered except `Wr_En` and `Wr_Addr` usage; `Wr_Addr` is a register, and `Wr_En` is combinational from `S_Valid` and registered `S_Ready`.
- Residency latency: Resident increments the cycle after the last word of a row is accepted.
- Issue latency: `Row_Compute_Sign` asserts 2 cycles after Resident reaches 3, i.e. one LOAD cycle plus the ISSUE register.
- Minimum gap between consecutive `Row_Compute_Sign` pulses: 3 cycles after `Row_Done`.

## Structure
- Shared package: state encodings (one-hot, same style as the other TJPU FSMs), `BANK_NUM`=4, and the bank-index width of 2.
- One natural sub-module: `row_ring_counter`, holding Wr_Bank, base, Resident and the write-completion/retire arithmetic. Everything else is in the top level.

## Test plan
- R=5, Cin=16 (W=5), continuous `S_Valid`, `Row_Done` 10 cycles after each issue:
  - expect 25 accepts and 3 `Row_Compute_Sign` pulses;
  - `Rd_Bank_Sel` = (2,1,0), (3,2,1), (0,3,2);
  - `Layer_Done` once.
- R=6, Cin=32 (W=12), `Row_Done` withheld: `S_Ready` drops after 48 accepts (Resident=4); releasing `Row_Done` resumes writes.
- Row write completion and `Row_Done` on the same cycle: Resident stays at 3 and the next issue occurs without stall.
- Start with R=2: `Layer_Done` pulses the cycle after Start; `S_Ready` stays 0 and no `M_Start`.
- Assert `rst` low mid-BUSY, then Start with R=4: fresh layer with banks starting at (2,1,0) and exactly 2 issues.
- Start pulse during BUSY: no effect; counters and `Rd_Bank_Sel` unchanged.
